// File: rtl/sevenseg_decode.sv
// Recovers four hex digits from a multiplexed active-low 7-segment scan.
// Each digit is captured after a stable dwell; a full set commits as one frame.
module sevenseg_decode #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       frame_strobe,
  output logic       frame_changed
);

  localparam logic [7:0] SettleW = 8'(SETTLE);

  typedef enum logic [0:0] {StWaitFrame, StCommit} state_e;

  state_e           state_q;
  logic [3:0]       an_q, an_p;
  logic [6:0]       seg_q, seg_p;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  shadow_val_q;
  logic [3:0]       shadow_err_q;

  logic             sel_ok, same, capture, last_digit;
  logic [1:0]       idx;
  logic [3:0]       dec_val;
  logic             dec_err;

  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    unique case (an_q)
      4'hE:    idx = 2'd0;
      4'hD:    idx = 2'd1;
      4'hB:    idx = 2'd2;
      4'h7:    idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_err = 1'b0;
    dec_val = 4'h0;
    case (seg_q)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    same = ({an_q, seg_q} == {an_p, seg_p});
    if (!sel_ok)              cnt_d = 8'd0;
    else if (!same)           cnt_d = 8'd1;
    else if (cnt_q < SettleW) cnt_d = cnt_q + 8'd1;
    else                      cnt_d = SettleW;
    // A saturated counter only re-fires when a new dwell starts (SETTLE=1 case).
    capture = sel_ok && (cnt_d == SettleW) && (!same || (cnt_q != SettleW));

    seen_d = (state_q == StCommit) ? 4'h0 : seen_q;
    if (capture) seen_d[idx] = 1'b1;
    last_digit = (state_q == StWaitFrame) && capture && (seen_d == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StWaitFrame;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      an_p          <= 4'hF;
      seg_p         <= 7'h7F;
      cnt_q         <= 8'd0;
      seen_q        <= 4'h0;
      shadow_val_q  <= '0;
      shadow_err_q  <= 4'h0;
      d3            <= 4'h0;
      d2            <= 4'h0;
      d1            <= 4'h0;
      d0            <= 4'h0;
      digit_err     <= 4'h0;
      frame_valid   <= 1'b0;
      frame_strobe  <= 1'b0;
      frame_changed <= 1'b0;
    end else begin
      an_q          <= an;
      seg_q         <= seg;
      an_p          <= an_q;
      seg_p         <= seg_q;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      frame_strobe  <= 1'b0;
      frame_changed <= 1'b0;
      if (capture) begin
        shadow_val_q[idx] <= dec_val;
        shadow_err_q[idx] <= dec_err;
      end
      case (state_q)
        StWaitFrame: begin
          if (last_digit) state_q <= StCommit;
        end
        StCommit: begin
          // Outputs take the shadow as it stood before any same-cycle capture.
          d3            <= shadow_val_q[3];
          d2            <= shadow_val_q[2];
          d1            <= shadow_val_q[1];
          d0            <= shadow_val_q[0];
          digit_err     <= shadow_err_q;
          frame_valid   <= 1'b1;
          frame_strobe  <= 1'b1;
          frame_changed <= !frame_valid ||
                           ({shadow_val_q, shadow_err_q} != {d3, d2, d1, d0, digit_err});
          state_q       <= StWaitFrame;
        end
        default: state_q <= StWaitFrame;
      endcase
    end
  end

endmodule
